// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one single-beat AXI
// write or read and returns the captured response, its latency and timeout status.
module axil_cmd_master #(
    parameter int          C_AXI_DATA_WIDTH = 32,
    parameter int          C_AXI_ADDR_WIDTH = 16,
    parameter int unsigned TIMEOUT_CYCLES   = 256
) (
    input  logic                          axi_aclk,
    input  logic                          axi_areset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [C_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic [15:0]                   rsp_latency,
    output logic                          timeout_flag,
    output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [C_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    // state | meaning
    // IDLE  | cmd_ready high, waiting for a command
    // WR    | AW and W channels outstanding, each retired independently
    // WB    | both write handshakes done, waiting for B
    // RA    | AR channel outstanding
    // RD    | waiting for R
    // RSP   | response presented until rsp_ready
    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;

    state_t      state;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        busy, resp_hs, aw_done, w_done;
    logic [15:0] lat_inc;

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    assign aw_hs   = m_axi_awvalid & m_axi_awready;
    assign w_hs    = m_axi_wvalid & m_axi_wready;
    assign b_hs    = m_axi_bvalid & m_axi_bready;
    assign ar_hs   = m_axi_arvalid & m_axi_arready;
    assign r_hs    = m_axi_rvalid & m_axi_rready;
    assign aw_done = !m_axi_awvalid || aw_hs;
    assign w_done  = !m_axi_wvalid || w_hs;
    assign busy    = (state == WR) || (state == WB) || (state == RA) || (state == RD);
    assign resp_hs = ((state == WB) && b_hs) || ((state == RD) && r_hs);
    assign lat_inc = (rsp_latency == 16'hFFFF) ? rsp_latency : rsp_latency + 16'd1;

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state         <= IDLE;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            rsp_latency   <= 16'd0;
            timeout_flag  <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready    <= 1'b0;
                        timeout_flag <= 1'b0;
                        rsp_latency  <= 16'd0;
                        if (cmd_write) begin
                            m_axi_awaddr  <= cmd_addr;
                            m_axi_wdata   <= cmd_wdata;
                            m_axi_wstrb   <= cmd_wstrb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WR;
                        end else begin
                            m_axi_araddr  <= cmd_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= RA;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WR: begin
                    if (aw_hs) m_axi_awvalid <= 1'b0;
                    if (w_hs)  m_axi_wvalid  <= 1'b0;
                    // a low valid in WR means that channel has already handshaken
                    if (aw_done && w_done) begin
                        m_axi_bready <= 1'b1;
                        state        <= WB;
                    end
                end
                WB: begin
                    if (b_hs) begin
                        rsp_resp     <= m_axi_bresp;
                        rsp_rdata    <= '0;
                        m_axi_bready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end
                RA: begin
                    if (ar_hs) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD;
                    end
                end
                RD: begin
                    if (r_hs) begin
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        m_axi_rready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // the count includes the response handshake cycle, then freezes in RSP
            if (busy) begin
                rsp_latency <= lat_inc;
                if (!resp_hs && ({16'd0, lat_inc} >= TIMEOUT_CYCLES))
                    timeout_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: timed AXI slave plus a cycle-level expectation model
// derived from handshake arithmetic, with directed and randomized transactions.
module tb_axil_cmd_master;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int TO = 16;

    logic          axi_aclk = 1'b0;
    logic          axi_areset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [15:0]   rsp_latency;
    logic          timeout_flag;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [2:0]    m_axi_awprot, m_axi_arprot;
    logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic [3:0]    m_axi_wstrb;
    logic [1:0]    m_axi_bresp, m_axi_rresp;
    logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic          m_axi_rvalid, m_axi_rready;

    int checks = 0;
    int failures = 0;
    bit [31:0] mem [int];

    always #5 axi_aclk = ~axi_aclk;

    axil_cmd_master #(
        .C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_latency(rsp_latency), .timeout_flag(timeout_flag),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    task automatic check1(input string tag, input int cyc, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkv(input string tag, input int cyc, input logic [63:0] obs,
                          input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
        m_axi_rdata = 32'hDEADBEEF; m_axi_rresp = 2'b11;
    endtask

    // Edge k counts from the accept edge (k=0); cycle n is the interval after edge n.
    // d_a/d_w: first cycle the slave raises awready(arready)/wready.
    // d_rsp: first cycle the slave raises bvalid/rvalid (may precede the ready).
    task automatic do_txn(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int d_a, input int d_w,
                          input int d_rsp, input logic [1:0] resp, input int hold,
                          input int abort_at);
        int ah, wh, dn, rh, rsph, lat, tcap;
        logic [31:0] rdata_exp, mask, old;
        bit resp_phase;
        ah = d_a + 1;
        wh = wr ? d_w + 1 : 0;
        dn = (ah > wh) ? ah : wh;
        rh = ((dn > d_rsp) ? dn : d_rsp) + 1;
        rsph = rh + hold + 1;
        lat = (rh > 65535) ? 65535 : rh;
        rdata_exp = 32'd0;
        if (!wr && mem.exists(int'(addr))) rdata_exp = mem[int'(addr)];

        check1("cmd_ready_before_accept", -1, cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        @(posedge axi_aclk);
        for (int n = 0; n <= rsph + 1; n++) begin
            @(negedge axi_aclk);
            check1("cmd_ready", n, cmd_ready, n == rsph + 1);
            if (wr) begin
                check1("awvalid", n, m_axi_awvalid, n < ah);
                check1("wvalid", n, m_axi_wvalid, n < wh);
                check1("bready", n, m_axi_bready, n >= dn && n < rh);
                check1("arvalid_idle", n, m_axi_arvalid, 1'b0);
                check1("rready_idle", n, m_axi_rready, 1'b0);
                if (n < ah) checkv("awaddr", n, 64'(m_axi_awaddr), 64'(addr));
                if (n < wh) checkv("wdata_wstrb", n, 64'({m_axi_wdata, m_axi_wstrb}),
                                   64'({data, strb}));
            end else begin
                check1("arvalid", n, m_axi_arvalid, n < ah);
                check1("rready", n, m_axi_rready, n >= ah && n < rh);
                check1("awvalid_idle", n, m_axi_awvalid, 1'b0);
                check1("wvalid_idle", n, m_axi_wvalid, 1'b0);
                check1("bready_idle", n, m_axi_bready, 1'b0);
                if (n < ah) checkv("araddr", n, 64'(m_axi_araddr), 64'(addr));
            end
            checkv("prot", n, 64'({m_axi_awprot, m_axi_arprot}), 64'd0);
            check1("rsp_valid", n, rsp_valid, n >= rh && n < rsph);
            if (n >= rh && n < rsph) begin
                checkv("rsp_rdata", n, 64'(rsp_rdata), wr ? 64'd0 : 64'(rdata_exp));
                checkv("rsp_resp", n, 64'(rsp_resp), 64'(resp));
                checkv("rsp_latency", n, 64'(rsp_latency), 64'(lat));
            end
            tcap = (n < rh - 1) ? n : rh - 1;
            check1("timeout_flag", n, timeout_flag, tcap >= TO);

            if (n == abort_at) begin
                axi_areset = 1'b1;
                #1;
                checkv("async_reset_ctrl", n, 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                       m_axi_arvalid, m_axi_rready, rsp_valid, cmd_ready, timeout_flag}), 64'd0);
                checkv("async_reset_latency", n, 64'(rsp_latency), 64'd0);
                idle_inputs();
                @(negedge axi_aclk);
                axi_areset = 1'b0;
                #1 check1("cmd_ready_at_release", n, cmd_ready, 1'b0);
                @(negedge axi_aclk);
                check1("cmd_ready_after_release", n, cmd_ready, 1'b1);
                return;
            end

            resp_phase = (n >= d_rsp) && (n < rh);
            cmd_valid = (hold > 0) && (n >= rh) && (n < rh + hold);
            cmd_write = ~wr; cmd_addr = addr ^ 16'h0010; cmd_wdata = ~data;
            m_axi_awready = wr && (n >= d_a);
            m_axi_wready  = wr && (n >= d_w);
            m_axi_bvalid  = wr && resp_phase;
            m_axi_bresp   = (wr && resp_phase) ? resp : 2'b11;
            m_axi_arready = !wr && (n >= d_a);
            m_axi_rvalid  = !wr && resp_phase;
            m_axi_rdata   = (!wr && resp_phase) ? rdata_exp : 32'hDEADBEEF;
            m_axi_rresp   = (!wr && resp_phase) ? resp : 2'b11;
            rsp_ready     = (n >= rh + hold);
            if (n == rsph + 1) idle_inputs();
        end
        if (wr) begin
            mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
            old = mem.exists(int'(addr)) ? mem[int'(addr)] : 32'd0;
            mem[int'(addr)] = (old & ~mask) | (data & mask);
        end
    endtask

    initial begin
        bit          r_wr;
        int          r_idx, r_da, r_dw, r_drsp, r_hold;
        logic [15:0] r_addr;
        logic [31:0] r_data;
        logic [3:0]  r_strb;
        logic [1:0]  r_resp;

        axi_areset = 1'b1;
        idle_inputs();
        @(negedge axi_aclk);
        checkv("reset_ctrl", 0, 64'({cmd_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid,
               m_axi_bready, m_axi_arvalid, m_axi_rready, timeout_flag}), 64'd0);
        checkv("reset_data", 0, 64'({rsp_latency, rsp_resp, m_axi_awaddr, m_axi_araddr}), 64'd0);
        checkv("reset_rdata", 0, 64'(rsp_rdata), 64'd0);
        @(negedge axi_aclk);
        axi_areset = 1'b0;
        @(negedge axi_aclk);
        check1("cmd_ready_after_por", 0, cmd_ready, 1'b1);

        do_txn(1'b1, 16'h0960, 32'h001F6000, 4'hF, 0, 0, 2, 2'b00, 0, -1);
        do_txn(1'b1, 16'h0004, 32'h00000001, 4'hF, 2, 0, 0, 2'b00, 0, -1);
        do_txn(1'b0, 16'h0004, 32'h0, 4'h0, 3, 0, 0, 2'b00, 0, -1);
        do_txn(1'b0, 16'h0960, 32'h0, 4'h0, 0, 0, 0, 2'b00, 10, -1);
        do_txn(1'b1, 16'h0100, 32'hCAFEF00D, 4'h5, 0, 0, 40, 2'b00, 0, -1);
        do_txn(1'b0, 16'h0100, 32'h0, 4'h0, 0, 0, 1, 2'b10, 0, -1);
        do_txn(1'b1, 16'h0200, 32'hA5A5_5A5A, 4'hF, 0, 0, 0, 2'b00, 0, -1);
        do_txn(1'b0, 16'h0200, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, -1);
        do_txn(1'b1, 16'h0008, 32'h12345678, 4'hF, 10, 10, 0, 2'b00, 0, 3);
        do_txn(1'b0, 16'h0000, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, -1);

        for (int i = 0; i < 40; i++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_idx  = int'($urandom_range(0, 600));
            r_addr = 16'(r_idx * 4);
            r_data = $urandom;
            r_strb = 4'($urandom_range(0, 15));
            r_da   = int'($urandom_range(0, 3));
            r_dw   = int'($urandom_range(0, 3));
            r_drsp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 24))
                                                 : int'($urandom_range(0, 5));
            r_resp = 2'($urandom_range(0, 3));
            r_hold = int'($urandom_range(0, 3));
            do_txn(r_wr, r_addr, r_data, r_strb, r_da, r_dw, r_drsp, r_resp, r_hold, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
